// File: rtl/riscv_pkg.sv
// Shared encodings for the MEM stage: funct3 load/store sizes, FSM states and byte-enable patterns.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_B   = 4'b0001;
  localparam logic [3:0] BE_HLO = 4'b0011;
  localparam logic [3:0] BE_HHI = 4'b1100;
  localparam logic [3:0] BE_W   = 4'b1111;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/lsu_align.sv
// Load/store formatting: store lane replication and byte enables, load extract/extend, misalign detect.
module lsu_align
  import riscv_pkg::*;
(
  input  logic        read,
  input  logic        write,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] store_src,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [3:0]  be,
  output logic        misaligned
);

  logic [15:0] lane;

  // Low 16 bits of the read word after shifting the addressed byte down to bit 0.
  assign lane = 16'(rdata >> {offset, 3'b000});

  always_comb begin
    wdata      = store_src;
    load_data  = rdata;
    be         = BE_W;
    misaligned = 1'b0;
    case (funct3)
      F3_B, F3_BU: begin
        wdata     = {4{store_src[7:0]}};
        be        = BE_B << offset;
        load_data = funct3[2] ? {24'b0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
      end
      F3_H, F3_HU: begin
        wdata      = {2{store_src[15:0]}};
        be         = offset[1] ? BE_HHI : BE_HLO;
        load_data  = funct3[2] ? {16'b0, lane} : {{16{lane[15]}}, lane};
        misaligned = offset[0];
      end
      F3_W: misaligned = (offset != 2'b00);
      default: misaligned = 1'b1;
    endcase
    // Unsigned variants exist only for loads.
    if (write && funct3[2]) misaligned = 1'b1;
    if (!(read || write)) misaligned = 1'b0;
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory handshake with wait/timeout, upstream stall,
// branch/jump redirect and the MEM/WB register.
module mem_stage
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Ctl_MemtoReg_in,
  input  logic        Ctl_RegWrite_in,
  input  logic        Ctl_MemRead_in,
  input  logic        Ctl_MemWrite_in,
  input  logic        Ctl_Branch_in,
  input  logic        jal_in,
  input  logic        jalr_in,
  input  logic        Zero_in,
  input  logic [4:0]  Rd_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] ALUresult_in,
  input  logic [31:0] ReadData2_in,
  input  logic [31:0] PCimm_in,
  input  logic [31:0] PC_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall_out,
  output logic        PCSrc_out,
  output logic        flush_out,
  output logic [31:0] PCtarget_out,
  output logic [31:0] mem_data_out,
  output logic        Ctl_MemtoReg_out,
  output logic        Ctl_RegWrite_out,
  output logic [4:0]  Rd_out,
  output logic [31:0] ReadData_out,
  output logic [31:0] ALUresult_out,
  output logic        misalign_out,
  output logic        bus_err_out
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             access;
  logic             misaligned;
  logic             timeout;
  logic             bubble;
  logic [31:0]      load_data;

  lsu_align u_align (
    .read       (Ctl_MemRead_in),
    .write      (Ctl_MemWrite_in),
    .funct3     (funct3_in),
    .offset     (ALUresult_in[1:0]),
    .store_src  (ReadData2_in),
    .rdata      (dmem_rdata),
    .wdata      (dmem_wdata),
    .load_data  (load_data),
    .be         (dmem_be),
    .misaligned (misaligned)
  );

  assign access    = Ctl_MemRead_in | Ctl_MemWrite_in;
  assign dmem_addr = {ALUresult_in[31:2], 2'b00};
  assign dmem_we   = Ctl_MemWrite_in;

  // The cycle after a timeout still holds the abandoned access, so it must not re-request.
  assign dmem_req  = !reset && ((state == WAIT) || (access && !misaligned && !bus_err_out));
  assign stall_out = dmem_req & ~dmem_ack;
  assign timeout   = (state == WAIT) && !dmem_ack && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign bubble    = stall_out | (access & misaligned) | bus_err_out;

  assign PCSrc_out    = (Ctl_Branch_in & Zero_in) | jal_in | jalr_in;
  assign flush_out    = PCSrc_out;
  assign PCtarget_out = jalr_in ? {ALUresult_in[31:1], 1'b0} : PCimm_in;
  assign mem_data_out = ALUresult_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      cnt              <= '0;
      misalign_out     <= 1'b0;
      bus_err_out      <= 1'b0;
      Ctl_MemtoReg_out <= 1'b0;
      Ctl_RegWrite_out <= 1'b0;
      Rd_out           <= '0;
      ReadData_out     <= '0;
      ALUresult_out    <= '0;
    end else begin
      misalign_out <= (state == IDLE) && access && misaligned;
      bus_err_out  <= timeout;
      case (state)
        IDLE: if (dmem_req && !dmem_ack) begin
          state <= WAIT;
          cnt   <= '0;
        end
        WAIT: begin
          if (dmem_ack || timeout) state <= IDLE;
          else cnt <= cnt + CNT_W'(1);
        end
        default: state <= IDLE;
      endcase
      Ctl_MemtoReg_out <= Ctl_MemtoReg_in & ~bubble;
      Ctl_RegWrite_out <= Ctl_RegWrite_in & ~bubble;
      if (!stall_out) begin
        Rd_out        <= Rd_in;
        ReadData_out  <= load_data;
        ALUresult_out <= (jal_in | jalr_in) ? PC_in + 32'd4 : ALUresult_in;
      end
    end
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage, directly downstream of the EX/MEM register.
- Consumes the registered EX outputs: ALU result, store data, PC+imm target, Zero, control bits, Rd.
- Performs the data-memory access over a req/ack handshake with a wait/timeout FSM, and formats loads and stores.
- Resolves branch/jal/jalr redirects and drives the MEM/WB register.
- Stalls the upstream pipeline while a memory access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles spent in WAIT without dmem_ack before the access is abandoned.
- CNT_W, 5: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
Ctl_MemtoReg_in, Ctl_RegWrite_in, Ctl_MemRead_in, Ctl_MemWrite_in, Ctl_Branch_in  in  1 each  EX/MEM control
jal_in, jalr_in, Zero_in  in  1 each  jump flags; ALU zero (1 = branch condition met)
Rd_in  in  5  destination register
funct3_in  in  3  load/store size and sign
ALUresult_in, ReadData2_in, PCimm_in, PC_in  in  32 each  address/result, store data, branch target, instruction PC
dmem_req, dmem_we  out  1 each  memory request; write enable
dmem_addr, dmem_wdata  out  32 each  word address {addr[31:2],2'b00}; replicated store data
dmem_be  out  4  byte enables
dmem_ack  in  1  access complete; rdata valid in the same cycle
dmem_rdata  in  32  read word
stall_out  out  1  hold PC/IF/ID/EX/EX-MEM registers
PCSrc_out, flush_out  out  1 each  redirect taken; flush younger stages
PCtarget_out  out  32  redirect target
mem_data_out  out  32  EX forwarding value (ForwardA/B = 2'b10 path) = ALUresult_in
Ctl_MemtoReg_out, Ctl_RegWrite_out  out  1 each  MEM/WB control
Rd_out  out  5  MEM/WB Rd
ReadData_out, ALUresult_out  out  32 each  extended load data; ALU result, or PC_in+4 for jal/jalr
misalign_out, bus_err_out  out  1 each  one-cycle error pulses

Behaviour:
Reset:
- reset=1 immediately forces state IDLE, counter 0, and all registered outputs to 0.
- Combinational outputs follow from IDLE state and the current inputs.

Access decode:
- access = MemRead|MemWrite.
- misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
- funct3 loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu. Stores: 000/001/010.
- Any other funct3 with access set is treated as misaligned.

FSM states:
- IDLE:
  - access & !misaligned: dmem_req=1, same cycle.
  - ack in the same cycle: zero-wait completion, stay in IDLE.
  - No ack: go to WAIT, counter cleared.
- WAIT:
  - dmem_req=1; counter increments each cycle.
  - ack: back to IDLE, MEM/WB captures.
  - counter==TIMEOUT_CYCLES-1 with no ack: bus_err_out=1 next cycle, back to IDLE, MEM/WB gets a bubble.
- dmem_ack while dmem_req=0 is ignored.

Stall:
- stall_out = dmem_req & !dmem_ack, combinational.
- Upstream holds the EX/MEM inputs stable while stalled, so dmem_addr/we/wdata/be are combinational from the held inputs.
- While stalled, MEM/WB loads a bubble: RegWrite_out=0, MemtoReg_out=0.

Stores:
- sb: wdata = byte replicated x4, be = 0001 << addr[1:0].
- sh: wdata = halfword replicated x2, be = addr[1] ? 1100 : 0011.
- sw: be = 1111.
- dmem_we = MemWrite.

Loads:
- Select the byte/halfword of dmem_rdata by addr[1:0]; sign-extend or zero-extend per funct3.

Misaligned access:
- No request is issued.
- misalign_out=1 for one cycle at the next edge.
- MEM/WB bubble.

Redirect (combinational, never coincides with a stall because jumps/branches do not access memory):
- PCSrc_out = (Branch & Zero_in) | jal_in | jalr_in.
- PCtarget_out = jalr_in ? {ALUresult_in[31:1],1'b0} : PCimm_in.
- flush_out = PCSrc_out.

MEM/WB register:
- Captured every non-stalled edge: control, Rd, ReadData, ALUresult_out.
- ALUresult_out = (jal|jalr) ? PC_in+4 : ALUresult_in.
- 32-bit wrap-around on PC_in+4 is allowed.

Reset mid-WAIT:
- dmem_req drops asynchronously.
- Any later ack is ignored.

Decomposition:
- riscv_pkg: funct3 load/store encodings, FSM state encoding (IDLE=0, WAIT=1), byte-enable constants.
- Sub-module lsu_align (combinational): store data replication and byte enables, load extract/extend, misalign detect.
- mem_stage: FSM, counter, stall, redirect, MEM/WB register.

Test Plan:
- sw addr 0x100, data 0xDEADBEEF, ack same cycle -> dmem_be=1111, stall_out never 1, RegWrite_out=0 next cycle.
- lb addr 0x103, rdata 0x80FF_FF_FF, ack after 3 cycles -> stall_out high 3 cycles, ReadData_out=0xFFFFFF80. Repeat as lbu -> 0x00000080.
- sh addr 0x202, data 0x1234 -> dmem_wdata=0x12341234, be=1100. lh addr 0x201 -> no dmem_req, misalign_out pulse, RegWrite_out=0.
- lw, no ack for TIMEOUT_CYCLES -> bus_err_out single pulse, stall_out drops, FSM back to IDLE; later stray ack ignored.
- beq Branch=1, Zero=1, PCimm=0x40 -> PCSrc_out=1, PCtarget_out=0x40. jalr ALUresult=0x87, PC=0x10 -> target 0x86, ALUresult_out=0x14.
- reset asserted in WAIT cycle 2 -> dmem_req=0 immediately, all outputs 0; after release, a new load completes normally.
